// File: rtl/pc_gen_ras.sv
// Fetch PC generator with execute redirect, decode-stage jump prediction and a circular return-address stack.
// The RAS is built only when PC_GEN_RAS_EN is defined; otherwise it reads as permanently empty.
module pc_gen_ras #(
   parameter int unsigned       WIDTH        = 32,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
   parameter int unsigned       RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             fetch_ready,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             pred_jump,
   input  logic [WIDTH-1:0] pred_target,
   input  logic             ras_push,
   input  logic [WIDTH-1:0] ras_push_addr,
   input  logic             ras_pop,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             fetch_valid,
   output logic             ras_empty,
   output logic             ras_full
);

   generate
      if (WIDTH < 3) begin : g_bad_width
         $error("pc_gen_ras: WIDTH must be >= 3");
      end
      if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("pc_gen_ras: RAS_DEPTH must be a power of two >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             fetch_valid_q;
   logic             ras_hit;
   logic [WIDTH-1:0] ras_top;

   // Decode-stage events only count when neither stalled nor flushed by execute.
   logic decode_ok;
   assign decode_ok = !redirect && !stall;

   assign pc_plus4 = pc_q + WIDTH'(4);

`ifdef PC_GEN_RAS_EN
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [PTR_W-1:0] top_q, top_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] entry_q [RAS_DEPTH];
   logic             do_push, do_pop;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;

   assign do_push = decode_ok && ras_push;
   assign do_pop  = decode_ok && ras_pop && (count_q != '0);
   assign ras_hit = do_pop;
   assign ras_top = entry_q[top_q];

   always_comb begin
      top_d   = top_q;
      count_d = count_q;
      wr_en   = 1'b0;
      wr_idx  = top_q;
      if (do_push && do_pop) begin
         // Return immediately followed by a call: replace the top in place.
         wr_en = 1'b1;
      end else if (do_push) begin
         top_d  = top_q + PTR_W'(1);
         wr_idx = top_q + PTR_W'(1);
         wr_en  = 1'b1;
         if (count_q != CNT_FULL) begin
            count_d = count_q + CNT_W'(1);
         end
      end else if (do_pop) begin
         top_d   = top_q - PTR_W'(1);
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_q   <= '0;
         count_q <= '0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               entry_q[gi] <= '0;
            end else if (wr_en && (wr_idx == PTR_W'(gi))) begin
               entry_q[gi] <= ras_push_addr;
            end
         end
      end
   endgenerate

   assign ras_empty = (count_q == '0);
   assign ras_full  = (count_q == CNT_FULL);
`else
   logic unused_ras_inputs;
   assign unused_ras_inputs = ^{ras_push, ras_pop, ras_push_addr};
   assign ras_hit   = 1'b0;
   assign ras_top   = '0;
   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
`endif

   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = redirect_target;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (ras_hit) begin
         pc_d = ras_top;
      end else if (pred_jump) begin
         pc_d = pred_target;
      end else if (!fetch_ready) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_VECTOR;
         fetch_valid_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         fetch_valid_q <= 1'b1;
      end
   end

   assign pc_out      = pc_q;
   assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: reset, back-pressure, stall, prediction, wrap and (when PC_GEN_RAS_EN is set) the RAS.
module tb_pc_gen_ras;
   localparam int unsigned WIDTH = 32;
   localparam logic [31:0] RV    = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        fetch_ready = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        pred_jump = 1'b0;
   logic [31:0] pred_target = '0;
   logic        ras_push = 1'b0;
   logic [31:0] ras_push_addr = '0;
   logic        ras_pop = 1'b0;
   logic [31:0] pc_out, pc_plus4;
   logic        fetch_valid, ras_empty, ras_full;

   int total = 0;
   int bad   = 0;

   pc_gen_ras #(.WIDTH(WIDTH), .RESET_VECTOR(RV), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
      .redirect(redirect), .redirect_target(redirect_target),
      .pred_jump(pred_jump), .pred_target(pred_target),
      .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
      .ras_empty(ras_empty), .ras_full(ras_full)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      $display("cycle: pc=%h valid=%0b empty=%0b full=%0b", pc_out, fetch_valid, ras_empty, ras_full);
   endtask

   task automatic go_to(input logic [31:0] a);
      redirect = 1'b1; redirect_target = a;
      step();
      redirect = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      total++; if (pc_out !== RV) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_out, RV); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fetch_valid); end
      total++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin bad++; $display("FAIL reset_ras got=%b%b exp=10", ras_empty, ras_full); end
      @(posedge clk); #1 rst = 1'b0;
      step();
      total++; if (pc_out !== 32'h1004 || fetch_valid !== 1'b1) begin bad++; $display("FAIL release1 got=%h/%b exp=00001004/1", pc_out, fetch_valid); end
      step();
      total++; if (pc_out !== 32'h1008) begin bad++; $display("FAIL release2 got=%h exp=00001008", pc_out); end
   endtask

   task automatic test_fetch_ready();
      go_to(32'h20);
      fetch_ready = 1'b0;
      step();
      total++; if (pc_out !== 32'h20) begin bad++; $display("FAIL fr_hold got=%h exp=00000020", pc_out); end
      redirect = 1'b1; redirect_target = 32'h400;
      step();
      redirect = 1'b0;
      total++; if (pc_out !== 32'h400) begin bad++; $display("FAIL fr_redirect got=%h exp=00000400", pc_out); end
      fetch_ready = 1'b1;
   endtask

   task automatic test_stall();
      go_to(32'h10);
      stall = 1'b1; pred_jump = 1'b1; pred_target = 32'h80;
      step();
      total++; if (pc_out !== 32'h10) begin bad++; $display("FAIL stall_hold got=%h exp=00000010", pc_out); end
      redirect = 1'b1; redirect_target = 32'h200;
      step();
      redirect = 1'b0; stall = 1'b0; pred_jump = 1'b0;
      total++; if (pc_out !== 32'h200) begin bad++; $display("FAIL stall_redirect got=%h exp=00000200", pc_out); end
   endtask

   task automatic test_pred_jump();
      go_to(32'h10);
      fetch_ready = 1'b0; pred_jump = 1'b1; pred_target = 32'h80;
      step();
      pred_jump = 1'b0;
      total++; if (pc_out !== 32'h80) begin bad++; $display("FAIL pred_jump got=%h exp=00000080", pc_out); end
      fetch_ready = 1'b1;
   endtask

   task automatic test_wrap();
      go_to(32'hFFFF_FFFC);
      total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL plus4_wrap got=%h exp=00000000", pc_plus4); end
      step();
      total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h exp=00000000", pc_out); end
   endtask

`ifdef PC_GEN_RAS_EN
   task automatic test_ras_lifo();
      logic [31:0] pushes [3];
      pushes[0] = 32'h104; pushes[1] = 32'h208; pushes[2] = 32'h30C;
      go_to(32'h500);
      for (int i = 0; i < 3; i++) begin
         ras_push = 1'b1; ras_push_addr = pushes[i];
         step();
      end
      ras_push = 1'b0;
      total++; if (pc_out !== 32'h50C || ras_empty !== 1'b0) begin bad++; $display("FAIL lifo_push got=%h/%b exp=0000050c/0", pc_out, ras_empty); end
      ras_pop = 1'b1;
      for (int i = 2; i >= 0; i--) begin
         step();
         total++; if (pc_out !== pushes[i]) begin bad++; $display("FAIL lifo_pop%0d got=%h exp=%h", i, pc_out, pushes[i]); end
      end
      total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL lifo_empty got=%b exp=1", ras_empty); end
      step();
      ras_pop = 1'b0;
      total++; if (pc_out !== 32'h108 || ras_empty !== 1'b1) begin bad++; $display("FAIL pop_empty got=%h/%b exp=00000108/1", pc_out, ras_empty); end
   endtask

   task automatic test_ras_overflow();
      go_to(32'h600);
      for (int i = 1; i <= 5; i++) begin
         ras_push = 1'b1; ras_push_addr = 32'(i * 16);
         step();
         if (i == 3) begin
            total++; if (ras_full !== 1'b0) begin bad++; $display("FAIL full_early got=%b exp=0", ras_full); end
         end
      end
      ras_push = 1'b0;
      total++; if (ras_full !== 1'b1) begin bad++; $display("FAIL full got=%b exp=1", ras_full); end
      ras_pop = 1'b1;
      for (int i = 5; i >= 3; i--) begin
         step();
         total++; if (pc_out !== 32'(i * 16)) begin bad++; $display("FAIL ovf_pop got=%h exp=%h", pc_out, 32'(i * 16)); end
      end
      total++; if (ras_full !== 1'b0) begin bad++; $display("FAIL full_clear got=%b exp=0", ras_full); end
      ras_push = 1'b1; ras_push_addr = 32'h99;
      step();
      ras_push = 1'b0;
      total++; if (pc_out !== 32'h20 || ras_empty !== 1'b0) begin bad++; $display("FAIL pushpop got=%h/%b exp=00000020/0", pc_out, ras_empty); end
      step();
      total++; if (pc_out !== 32'h99 || ras_empty !== 1'b1) begin bad++; $display("FAIL replaced_top got=%h/%b exp=00000099/1", pc_out, ras_empty); end
      ras_pop = 1'b0;
   endtask

   task automatic test_ras_corner();
      go_to(32'h700);
      ras_push = 1'b1; ras_pop = 1'b1; ras_push_addr = 32'h77;
      step();
      ras_push = 1'b0;
      total++; if (pc_out !== 32'h704 || ras_empty !== 1'b0) begin bad++; $display("FAIL pushpop_empty got=%h/%b exp=00000704/0", pc_out, ras_empty); end
      step();
      ras_pop = 1'b0;
      total++; if (pc_out !== 32'h77) begin bad++; $display("FAIL pushpop_empty_pop got=%h exp=00000077", pc_out); end
      redirect = 1'b1; redirect_target = 32'h800; ras_push = 1'b1; ras_push_addr = 32'h55;
      step();
      redirect = 1'b0;
      total++; if (pc_out !== 32'h800 || ras_empty !== 1'b1) begin bad++; $display("FAIL redirect_discard got=%h/%b exp=00000800/1", pc_out, ras_empty); end
      stall = 1'b1;
      step();
      stall = 1'b0; ras_push = 1'b0;
      total++; if (pc_out !== 32'h800 || ras_empty !== 1'b1) begin bad++; $display("FAIL stall_discard got=%h/%b exp=00000800/1", pc_out, ras_empty); end
      ras_push = 1'b1; ras_push_addr = 32'h66;
      step();
      ras_push = 1'b0; ras_pop = 1'b1; redirect = 1'b1; redirect_target = 32'h900;
      step();
      redirect = 1'b0;
      total++; if (pc_out !== 32'h900 || ras_empty !== 1'b0) begin bad++; $display("FAIL redirect_pop got=%h/%b exp=00000900/0", pc_out, ras_empty); end
      step();
      ras_pop = 1'b0;
      total++; if (pc_out !== 32'h66) begin bad++; $display("FAIL pop_after_redirect got=%h exp=00000066", pc_out); end
   endtask

   task automatic test_async_reset();
      ras_push = 1'b1; ras_push_addr = 32'hA0;
      step();
      ras_push_addr = 32'hB0;
      step();
      ras_push = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++; if (pc_out !== RV || ras_empty !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("FAIL async_reset got=%h/%b/%b exp=%h/1/0", pc_out, ras_empty, fetch_valid, RV); end
      @(posedge clk); #1 rst = 1'b0;
      ras_pop = 1'b1;
      step();
      ras_pop = 1'b0;
      total++; if (pc_out !== 32'h1004 || ras_empty !== 1'b1) begin bad++; $display("FAIL reset_clears_ras got=%h/%b exp=00001004/1", pc_out, ras_empty); end
   endtask
`else
   task automatic test_no_ras();
      go_to(32'h300);
      ras_push = 1'b1; ras_push_addr = 32'h44;
      step();
      ras_push = 1'b0;
      total++; if (pc_out !== 32'h304 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin bad++; $display("FAIL no_ras_push got=%h/%b%b exp=00000304/10", pc_out, ras_empty, ras_full); end
      ras_pop = 1'b1;
      step();
      ras_pop = 1'b0;
      total++; if (pc_out !== 32'h308) begin bad++; $display("FAIL no_ras_pop got=%h exp=00000308", pc_out); end
   endtask

   task automatic test_async_reset();
      go_to(32'h340);
      #2 rst = 1'b1;
      #1;
      total++; if (pc_out !== RV || fetch_valid !== 1'b0) begin bad++; $display("FAIL async_reset got=%h/%b exp=%h/0", pc_out, fetch_valid, RV); end
      @(posedge clk); #1 rst = 1'b0;
      step();
      total++; if (pc_out !== 32'h1004) begin bad++; $display("FAIL after_reset got=%h exp=00001004", pc_out); end
   endtask
`endif

   initial begin
      test_reset();
      test_fetch_ready();
      test_stall();
      test_pred_jump();
      test_wrap();
`ifdef PC_GEN_RAS_EN
      test_ras_lifo();
      test_ras_overflow();
      test_ras_corner();
`else
      test_no_ras();
`endif
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
